rf_hazard_scoreboard: RTL and testbench
=======================================

Name: rf_hazard_scoreboard

Overview:
- Sequences operand delivery for the ID stage of the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Tracks in-flight register writes in a per-register pending-count scoreboard, selects bypass data from the EX/MEM/WB forwarding buses, and raises the ID stall.
- Runs a drain FSM for serialising instructions (fence/ecall): ID holds until every outstanding write has retired.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2^CNT_W-1.
- NREG, 32, architectural registers; x0 is never tracked.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_issue  in  1  instruction leaves ID this cycle; upstream guarantees id_valid & ~id_stall
- id_rs1 / id_rs2  in  5 each  source register numbers
- id_rs1_used / id_rs2_used  in  1 each  source is read
- id_wen  in  1  issuing instruction writes RF
- id_waddr  in  5  its destination
- id_fence  in  1  ID instruction is serialising
- ex_fw_wen, ex_fw_ok  in  1 each  EX holds a write; result already valid
- ex_fw_waddr  in  5;  ex_fw_wdata  in  32
- mem_fw_wen, mem_fw_ok, mem_fw_waddr, mem_fw_wdata  in  1/1/5/32  same for MEM; ok=0 while a load is outstanding
- wb_fw_wen, wb_fw_waddr, wb_fw_wdata  in  1/5/32  WB write, always valid
- rf_rdata1 / rf_rdata2  in  32 each  raw RF read data
- rs1_value / rs2_value  out  32 each  bypassed operands
- id_stall  out  1  ID must hold
- fence_ack  out  1  one-cycle pulse: drain complete
- busy_any  out  1  any counter nonzero
- sb_err  out  1  sticky: retire to a zero counter

Behaviour:
- Counters: cnt[r] registered, reset 0. cnt[0] is held at 0; writes to x0 are ignored.
  - Issue when id_issue & id_wen & id_waddr!=0.
  - Retire when wb_fw_wen & wb_fw_waddr!=0, one per cycle.
  - At the next edge: issue only → +1; retire only → -1; both to the same r → unchanged.
  - Retire with cnt=0: no change; sb_err set until rst.
- Issue latency: an issue in cycle N makes the register busy from N+1. A retire in cycle N clears it at N+1; during N the WB bus supplies the data.
- Bypass (combinational), per used source s != 0, priority EX > MEM > WB > RF:
  - The first bus with wen & waddr==s is selected; its wdata drives the value.
  - If no bus matches, the value is rf_rdata.
  - s==0 or unused: the value is rf_rdata.
- Source hazard: cnt[s]!=0 and either no bus matches, or the highest-priority match has ok=0. A lower-priority match never overrides a not-ok higher one.
- Overflow hazard: id_wen & cnt[id_waddr]==max & no retire to id_waddr this cycle.
- FSM (registered, reset IDLE):
  - IDLE: id_valid & id_fence → DRAIN.
  - DRAIN: id_stall=1; when all counters are 0 and no issue is pending → ACK.
  - ACK: fence_ack=1, id_stall=0 for one cycle; then IDLE. In ACK, id_fence is not re-evaluated.
  - rst mid-DRAIN → IDLE with counters cleared.
- id_stall = id_valid & (source hazard | overflow hazard | state==DRAIN | (state==IDLE & id_fence)).
- busy_any = OR of all counters.
- Reset values: all outputs 0; rs*_value follow rf_rdata.

Optional Feature:
- Macro SB_STALL_CNT_EN adds output hazard_stall_cnt (32 bits, reset 0).
  - Increments each cycle with id_valid & id_stall & state!=DRAIN, excluding fence-entry cycles.
  - Wraps at 2^32.
- Without the macro: the port and counter are absent; the behaviour of everything else is identical.

Test Plan:
- Issue x5 write, next cycle ID reads x5 with ex_fw_wen=1, ex_fw_waddr=5, ex_fw_ok=1, wdata=0x1234 → id_stall=0, rs1_value=0x1234; cnt[5]=1.
- Load to x7 in EX (ok=0), ID reads x7 → id_stall=1 for that cycle. Load moves to MEM, mem_fw_ok=1, wdata=0xBEEF → id_stall=0, rs1_value=0xBEEF.
- EX wen x3 ok=0 and MEM wen x3 ok=1 simultaneously → stall; MEM value not used.
- Three back-to-back x9 issues with no retire (CNT_W=2), fourth ID instruction writes x9 → overflow stall. Retire once → stall clears the same cycle; cnt goes 3→3 (issue+retire).
- Fence with cnt[4]=1 and cnt[6]=2; retires at cycles 2,3,4 → id_stall high throughout DRAIN; fence_ack pulses one cycle after the last retire; then IDLE. Repeat with rst in DRAIN → IDLE, busy_any=0.
- Retire x11 with cnt[11]=0 → sb_err=1, held until rst. Write/read x0 → never stalls, rs1_value=rf_rdata1.

Source files
------------

// File: rtl/rf_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_hazard_scoreboard
//
// Operand sequencer for the ID stage of a 5-stage pipeline. It keeps a
// pending-write counter for each architectural register, bypasses operands
// from the EX/MEM/WB forwarding buses and generates the ID stall. A drain
// FSM serialises fence/ecall: ID holds until every outstanding write has
// retired. It then pulses fence_ack for one cycle.
//
// Optional build macro: SB_STALL_CNT_EN adds the hazard_stall_cnt output.
// That output counts hazard stall cycles. Drain and fence-entry cycles are
// not counted.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   id_valid / id_issue               ID holds an instruction / it leaves ID
//   id_rs1, id_rs2, id_rs*_used       source registers and their read enables
//   id_wen, id_waddr                  destination of the issuing instruction
//   id_fence                          ID instruction is serialising
//   ex_fw_*, mem_fw_*                 forwarding buses (ok=0: result not ready)
//   wb_fw_*                           writeback bus (always valid, retires)
//   rf_rdata1, rf_rdata2              raw register file read data
//   rs1_value, rs2_value              bypassed operands
//   id_stall                          ID must hold
//   fence_ack                         one-cycle pulse: drain complete
//   busy_any                          some register has a pending write
//   sb_err                            sticky: retire hit a zero counter
//   hazard_stall_cnt (optional)       hazard stall cycle counter
// ---------------------------------------------------------------------------
module rf_hazard_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_issue,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_wen,
  input  logic [4:0]  id_waddr,
  input  logic        id_fence,
  input  logic        ex_fw_wen,
  input  logic        ex_fw_ok,
  input  logic [4:0]  ex_fw_waddr,
  input  logic [31:0] ex_fw_wdata,
  input  logic        mem_fw_wen,
  input  logic        mem_fw_ok,
  input  logic [4:0]  mem_fw_waddr,
  input  logic [31:0] mem_fw_wdata,
  input  logic        wb_fw_wen,
  input  logic [4:0]  wb_fw_waddr,
  input  logic [31:0] wb_fw_wdata,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] rs1_value,
  output logic [31:0] rs2_value,
  output logic        id_stall,
  output logic        fence_ack,
  output logic        busy_any,
  output logic        sb_err
`ifdef SB_STALL_CNT_EN
  ,
  output logic [31:0] hazard_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ACK} state_t;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic   sb_err_q;
  logic   issue_en, retire_en;
  logic   rs1_haz, rs2_haz, ovf_haz;
  logic   drain_hold, fence_entry;

  assign issue_en  = id_issue & id_wen & (id_waddr != 5'd0);
  assign retire_en = wb_fw_wen & (wb_fw_waddr != 5'd0);

  // Per-register next count. An issue and a retire to the same register
  // cancel out. A retire to an empty counter leaves it at zero; sb_err
  // records that event.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign cnt_d[gi] = '0;
      end else begin : g_reg
        localparam logic [4:0] REG_IDX = 5'(gi);
        logic inc, dec;
        assign inc = issue_en  & (id_waddr    == REG_IDX);
        assign dec = retire_en & (wb_fw_waddr == REG_IDX);
        assign cnt_d[gi] = (inc & ~dec & (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + CNT_W'(1) :
                           (dec & ~inc & (cnt_q[gi] != '0))      ? cnt_q[gi] - CNT_W'(1) :
                                                                   cnt_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (retire_en && cnt_q[wb_fw_waddr] == '0)
        sb_err_q <= 1'b1;
    end
  end

  // The return value is {hazard, operand}. The highest-priority matching
  // bus decides both the data and the readiness. A ready lower-priority
  // match never hides a not-ready younger producer.
  function automatic logic [32:0] bypass(input logic [4:0] s, input logic used,
                                         input logic [31:0] rf, input logic [CNT_W-1:0] cnt);
    logic        ex_hit, mem_hit, wb_hit, haz;
    logic [31:0] val;
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    wb_hit  = 1'b0;
    haz     = 1'b0;
    val     = rf;
    if (used && s != 5'd0) begin
      ex_hit  = ex_fw_wen  && (ex_fw_waddr  == s);
      mem_hit = mem_fw_wen && (mem_fw_waddr == s);
      wb_hit  = wb_fw_wen  && (wb_fw_waddr  == s);
      if (ex_hit)       val = ex_fw_wdata;
      else if (mem_hit) val = mem_fw_wdata;
      else if (wb_hit)  val = wb_fw_wdata;
      haz = (cnt != '0) && (ex_hit ? ~ex_fw_ok : (mem_hit ? ~mem_fw_ok : ~wb_hit));
    end
    return {haz, val};
  endfunction

  always_comb begin
    {rs1_haz, rs1_value} = bypass(id_rs1, id_rs1_used, rf_rdata1, cnt_q[id_rs1]);
    {rs2_haz, rs2_value} = bypass(id_rs2, id_rs2_used, rf_rdata2, cnt_q[id_rs2]);
  end

  // A retire in this cycle frees a slot, so a full counter need not stall.
  assign ovf_haz = id_wen & (cnt_q[id_waddr] == CNT_MAX) &
                   ~(retire_en & (wb_fw_waddr == id_waddr));

  // The drain completes on the next-state counters. This lets the ack
  // follow the final retire by one cycle, and an issue in the same cycle
  // keeps the drain open.
  always_comb begin
    state_d     = state_q;
    drain_hold  = 1'b0;
    fence_entry = 1'b0;
    fence_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fence_entry = id_fence;
        if (id_valid && id_fence) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_hold = 1'b1;
        if (cnt_d == '0) state_d = ST_ACK;
      end
      ST_ACK: begin
        fence_ack = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign id_stall = id_valid & (rs1_haz | rs2_haz | ovf_haz | drain_hold | fence_entry);
  assign busy_any = |cnt_q;
  assign sb_err   = sb_err_q;

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (id_valid && id_stall && !drain_hold && !fence_entry)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign hazard_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rf_hazard_scoreboard
//
// This bench uses a scoreboard. The driver applies inputs each cycle, just
// after the rising edge. It computes the expected outputs from a reference
// model made of integer pending counts and a drain mode, and it pushes them
// into a queue. The monitor pops one entry on each falling edge and compares
// it against the DUT. Directed scenarios run first. Randomized traffic
// follows.
// ---------------------------------------------------------------------------
module tb_rf_hazard_scoreboard;

  localparam int CMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_issue, id_rs1_used, id_rs2_used, id_wen, id_fence;
  logic [4:0]  id_rs1, id_rs2, id_waddr;
  logic        ex_fw_wen, ex_fw_ok, mem_fw_wen, mem_fw_ok, wb_fw_wen;
  logic [4:0]  ex_fw_waddr, mem_fw_waddr, wb_fw_waddr;
  logic [31:0] ex_fw_wdata, mem_fw_wdata, wb_fw_wdata, rf_rdata1, rf_rdata2;
  logic [31:0] rs1_value, rs2_value;
  logic        id_stall, fence_ack, busy_any, sb_err;
`ifdef SB_STALL_CNT_EN
  logic [31:0] hazard_stall_cnt;
`endif

  rf_hazard_scoreboard #(.CNT_W(2), .NREG(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_issue(id_issue),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_wen(id_wen), .id_waddr(id_waddr), .id_fence(id_fence),
    .ex_fw_wen(ex_fw_wen), .ex_fw_ok(ex_fw_ok), .ex_fw_waddr(ex_fw_waddr), .ex_fw_wdata(ex_fw_wdata),
    .mem_fw_wen(mem_fw_wen), .mem_fw_ok(mem_fw_ok), .mem_fw_waddr(mem_fw_waddr), .mem_fw_wdata(mem_fw_wdata),
    .wb_fw_wen(wb_fw_wen), .wb_fw_waddr(wb_fw_waddr), .wb_fw_wdata(wb_fw_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .id_stall(id_stall),
    .fence_ack(fence_ack), .busy_any(busy_any), .sb_err(sb_err)
`ifdef SB_STALL_CNT_EN
    , .hazard_stall_cnt(hazard_stall_cnt)
`endif
  );

  // Reference model state.
  int          pcnt[32];
  int          mode;      // 0 idle, 1 draining, 2 acknowledging
  bit          serr;
  logic [31:0] scnt;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        st;
    logic        ack;
    logic        busy;
    logic        err;
    logic [31:0] sc;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   txn = 0;
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req, input int id);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL txn %0d %s: actual %h required %h", id, nm, act, req);
    end
  endtask

  // Operand and hazard for one source, taken directly from the rules.
  function automatic void eval_src(input logic [4:0] s, input logic used, input logic [31:0] rf,
                                   output logic [31:0] val, output logic haz);
    logic        bw[3];
    logic [4:0]  ba[3];
    logic [31:0] bd[3];
    logic        bok[3];
    int          hit;
    bw  = '{ex_fw_wen, mem_fw_wen, wb_fw_wen};
    ba  = '{ex_fw_waddr, mem_fw_waddr, wb_fw_waddr};
    bd  = '{ex_fw_wdata, mem_fw_wdata, wb_fw_wdata};
    bok = '{ex_fw_ok, mem_fw_ok, 1'b1};
    hit = -1;
    val = rf;
    haz = 1'b0;
    if (used && s != 0) begin
      for (int b = 0; b < 3; b++)
        if (hit < 0 && bw[b] && ba[b] == s) hit = b;
      if (hit >= 0) val = bd[hit];
      haz = (pcnt[s] != 0) && (hit < 0 || !bok[hit]);
    end
  endfunction

  // Record the expected outputs for the current inputs. Then advance the
  // model across the edge and wait for that edge.
  task automatic step(input bit auto_issue);
    exp_t e;
    logic h1, h2, ovf;
    int   nc[32];
    bit   iss, ret, all_zero;
    eval_src(id_rs1, id_rs1_used, rf_rdata1, e.r1, h1);
    eval_src(id_rs2, id_rs2_used, rf_rdata2, e.r2, h2);
    ovf = id_wen && pcnt[id_waddr] == CMAX &&
          !(wb_fw_wen && wb_fw_waddr != 0 && wb_fw_waddr == id_waddr);
    e.st = id_valid && (h1 || h2 || ovf || mode == 1 || (mode == 0 && id_fence));
    if (auto_issue) id_issue = id_valid && !e.st && ($urandom_range(3) != 0);
    e.ack  = (mode == 2);
    e.busy = 1'b0;
    for (int r = 0; r < 32; r++) if (pcnt[r] != 0) e.busy = 1'b1;
    e.err = serr;
    e.sc  = scnt;
    e.id  = txn++;
    sbq.push_back(e);
    if (rst) begin
      for (int r = 0; r < 32; r++) pcnt[r] = 0;
      mode = 0; serr = 0; scnt = 0;
    end else begin
      iss = id_issue && id_wen && id_waddr != 0;
      ret = wb_fw_wen && wb_fw_waddr != 0;
      nc  = pcnt;
      if (ret && pcnt[wb_fw_waddr] == 0) serr = 1;
      if (!(iss && ret && id_waddr == wb_fw_waddr)) begin
        if (iss) nc[id_waddr]++;
        if (ret && pcnt[wb_fw_waddr] > 0) nc[wb_fw_waddr]--;
      end
      if (id_valid && e.st && mode != 1 && !(mode == 0 && id_fence)) scnt = scnt + 32'd1;
      all_zero = 1;
      for (int r = 0; r < 32; r++) if (nc[r] != 0) all_zero = 0;
      case (mode)
        0: if (id_valid && id_fence) mode = 1;
        1: if (all_zero) mode = 2;
        default: mode = 0;
      endcase
      pcnt = nc;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison set per transaction.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rs1_value", rs1_value, e.r1, e.id);
      chk("rs2_value", rs2_value, e.r2, e.id);
      chk("id_stall", {31'd0, id_stall}, {31'd0, e.st}, e.id);
      chk("fence_ack", {31'd0, fence_ack}, {31'd0, e.ack}, e.id);
      chk("busy_any", {31'd0, busy_any}, {31'd0, e.busy}, e.id);
      chk("sb_err", {31'd0, sb_err}, {31'd0, e.err}, e.id);
`ifdef SB_STALL_CNT_EN
      chk("hazard_stall_cnt", hazard_stall_cnt, e.sc, e.id);
`endif
      $display("txn %0d stall=%0b ack=%0b busy=%0b err=%0b rs1=%h rs2=%h",
               e.id, id_stall, fence_ack, busy_any, sb_err, rs1_value, rs2_value);
    end
  end

  task automatic clr();
    id_valid = 0; id_issue = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_wen = 0; id_waddr = 0; id_fence = 0;
    ex_fw_wen = 0; ex_fw_ok = 0; ex_fw_waddr = 0; ex_fw_wdata = 32'h0;
    mem_fw_wen = 0; mem_fw_ok = 0; mem_fw_waddr = 0; mem_fw_wdata = 32'h0;
    wb_fw_wen = 0; wb_fw_waddr = 0; wb_fw_wdata = 32'h0;
    rf_rdata1 = 32'hA1A1_0001; rf_rdata2 = 32'hB2B2_0002;
  endtask

  task automatic iss(input logic [4:0] r, input logic fence);
    clr(); id_valid = 1; id_wen = 1; id_waddr = r; id_issue = 1; id_fence = fence;
    step(0);
  endtask

  task automatic do_reset();
    clr(); rst = 1; step(0); rst = 0;
  endtask

  task automatic rand_in();
    logic [4:0] r;
    id_valid    = ($urandom_range(9) != 0);
    id_rs1      = 5'($urandom_range(7));
    id_rs2      = 5'($urandom_range(7));
    id_rs1_used = 1'($urandom_range(1));
    id_rs2_used = 1'($urandom_range(1));
    id_wen      = 1'($urandom_range(1));
    id_waddr    = 5'($urandom_range(7));
    id_fence    = ($urandom_range(15) == 0);
    ex_fw_wen   = 1'($urandom_range(1));
    ex_fw_ok    = 1'($urandom_range(1));
    ex_fw_waddr = 5'($urandom_range(7));
    ex_fw_wdata = $urandom;
    mem_fw_wen  = 1'($urandom_range(1));
    mem_fw_ok   = 1'($urandom_range(1));
    mem_fw_waddr = 5'($urandom_range(7));
    mem_fw_wdata = $urandom;
    r = 5'($urandom_range(7));
    wb_fw_wen   = (pcnt[r] > 0) ? ($urandom_range(2) != 0) : ($urandom_range(40) == 0);
    wb_fw_waddr = r;
    wb_fw_wdata = $urandom;
    rf_rdata1   = $urandom;
    rf_rdata2   = $urandom;
    rst         = ($urandom_range(299) == 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) pcnt[r] = 0;
    mode = 0; serr = 0; scnt = 0;
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    step(0);
    step(0);
    rst = 0;

    // Forward from EX on the cycle after the issue.
    iss(5'd5, 0);
    clr(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    ex_fw_wen = 1; ex_fw_waddr = 5; ex_fw_ok = 1; ex_fw_wdata = 32'h1234; step(0);
    // Load to x7: stall while it sits in EX, then forward from MEM.
    iss(5'd7, 0);
    clr(); id_valid = 1; id_rs1 = 7; id_rs1_used = 1; ex_fw_wen = 1; ex_fw_waddr = 7; step(0);
    clr(); id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
    mem_fw_wen = 1; mem_fw_waddr = 7; mem_fw_ok = 1; mem_fw_wdata = 32'hBEEF; step(0);
    // x3: a not-ready EX producer masks a ready MEM producer.
    iss(5'd3, 0);
    clr(); id_valid = 1; id_rs2 = 3; id_rs2_used = 1; ex_fw_wen = 1; ex_fw_waddr = 3;
    mem_fw_wen = 1; mem_fw_waddr = 3; mem_fw_ok = 1; mem_fw_wdata = 32'h3333; step(0);
    // Overflow of x9, then a same-cycle retire clears it.
    do_reset();
    iss(5'd9, 0); iss(5'd9, 0); iss(5'd9, 0);
    clr(); id_valid = 1; id_wen = 1; id_waddr = 9; step(0);
    clr(); id_valid = 1; id_wen = 1; id_waddr = 9; id_issue = 1;
    wb_fw_wen = 1; wb_fw_waddr = 9; wb_fw_wdata = 32'h9999; step(0);
    clr(); id_valid = 1; id_wen = 1; id_waddr = 9; step(0);
    // Fence drains cnt[4]=1 and cnt[6]=2.
    do_reset();
    iss(5'd4, 0); iss(5'd6, 0); iss(5'd6, 0);
    clr(); id_valid = 1; id_fence = 1; step(0);
    for (int k = 0; k < 3; k++) begin
      clr(); id_valid = 1; id_fence = 1; wb_fw_wen = 1; wb_fw_waddr = (k == 0) ? 5'd4 : 5'd6;
      step(0);
    end
    clr(); id_valid = 1; id_fence = 1; step(0);
    clr(); step(0);
    clr(); step(0);
    // Reset in the middle of a drain.
    iss(5'd4, 0);
    clr(); id_valid = 1; id_fence = 1; step(0);
    clr(); id_valid = 1; id_fence = 1; step(0);
    clr(); id_valid = 1; id_fence = 1; rst = 1; step(0); rst = 0;
    clr(); step(0);
    // Retire to an empty counter, then traffic on x0.
    clr(); wb_fw_wen = 1; wb_fw_waddr = 11; step(0);
    clr(); step(0);
    clr(); id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_wen = 1; id_waddr = 0; id_issue = 1;
    ex_fw_wen = 1; ex_fw_waddr = 0; ex_fw_wdata = 32'hDEAD; step(0);
    clr(); id_valid = 1; id_rs1 = 0; id_rs1_used = 1; step(0);
    do_reset();

    repeat (3000) begin
      rand_in();
      step(1);
    end

    chk("queue_drained", 32'(sbq.size()), 32'd0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
